// File: rtl/imm_gen_pkg.sv
// -----------------------------------------------------------------------------
// imm_gen_pkg
// Shared types and constants for the pipelined immediate generator.
//   imm_fmt_e      : format tag carried with every decoded immediate
//   skid_state_e   : occupancy of the 2-entry output skid buffer
//   OPC_*          : RV32I/RV64I major opcodes (inst[6:0]) that carry immediates
// The entry record (inst, tag, imm, fmt) is declared inside imm_gen_pipe
// because its tag and immediate widths follow that module's parameters.
// -----------------------------------------------------------------------------
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
// Pure combinational immediate decoder: instruction word -> sign-extended
// immediate plus format tag. Unknown opcodes give imm=0, fmt=FMT_NONE.
// Optional macro IMM_GEN_ZICSR_EN: csrr*i (SYSTEM, funct3[2]=1) decode the
// 5-bit zero-extended uimm as FMT_Z; otherwise SYSTEM decodes as FMT_NONE.
// Ports:
//   inst : in  32    instruction word
//   imm  : out XLEN  decoded immediate
//   fmt  : out 3     imm_fmt_e code
// -----------------------------------------------------------------------------
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt
);

  // Every format fits in 32 bits; widening to XLEN is a plain sign copy of
  // bit 31 (FMT_Z keeps bit 31 clear, so it zero-extends naturally).
  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    fmt   = FMT_NONE;
    case (inst[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        imm32 = {{20{inst[31]}}, inst[31:20]};
        fmt   = FMT_I;
      end
      OPC_OPIMM32: begin
        // Word-sized op-imm only exists on RV64.
        if (XLEN == 64) begin
          imm32 = {{20{inst[31]}}, inst[31:20]};
          fmt   = FMT_I;
        end
      end
      OPC_STORE: begin
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        fmt   = FMT_S;
      end
      OPC_BRANCH: begin
        imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        fmt   = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32 = {inst[31:12], 12'b0};
        fmt   = FMT_U;
      end
      OPC_JAL: begin
        imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        fmt   = FMT_J;
      end
`ifdef IMM_GEN_ZICSR_EN
      OPC_SYSTEM: begin
        if (inst[14]) begin
          imm32 = {27'b0, inst[19:15]};
          fmt   = FMT_Z;
        end
      end
`endif
      default: begin
        imm32 = '0;
        fmt   = FMT_NONE;
      end
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Registered immediate generator between the fetch register and the decode
// operand mux. Each accepted instruction is decoded on capture and stored,
// with its tag and passthrough word, in a 2-entry skid buffer.
// Optional macro IMM_GEN_ZICSR_EN enables FMT_Z decode in imm_decode.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid come straight from flops, so there is
// no combinational path from out_ready to in_ready. Once out_valid is high
// the entry on out_* stays put until it is taken (or flushed/reset).
//
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   flush               : synchronous kill of all buffered entries
//   in_valid/in_ready   : upstream handshake; in_inst, in_tag payload
//   out_valid/out_ready : downstream handshake; out_inst, out_tag, out_imm,
//                         out_fmt payload
//   dbg_state           : skid buffer state (skid_state_e encoding)
// -----------------------------------------------------------------------------
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [1:0]       dbg_state
);

  typedef struct packed {
    logic [31:0]      inst;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
  } imm_entry_t;

  imm_entry_t  dec_entry;
  imm_entry_t  slot_a;     // entry presented on out_*
  imm_entry_t  slot_b;     // skid entry caught while out_ready was low
  skid_state_e state_q;
  skid_state_e state_d;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        in_fire;
  logic        out_fire;
  logic        load_a;
  logic        a_from_b;
  logic        load_b;
  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst (in_inst),
    .imm  (dec_imm),
    .fmt  (dec_fmt)
  );

  always_comb begin
    dec_entry.inst = in_inst;
    dec_entry.tag  = in_tag;
    dec_entry.imm  = dec_imm;
    dec_entry.fmt  = dec_fmt;
  end

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d  = state_q;
    load_a   = 1'b0;
    a_from_b = 1'b0;
    load_b   = 1'b0;
    if (flush) begin
      // Flush wins over any same-cycle input; nothing is loaded.
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (in_fire) begin
            load_a  = 1'b1;
            state_d = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (in_fire && out_fire) begin
            load_a = 1'b1;
          end else if (in_fire) begin
            load_b  = 1'b1;
            state_d = SKID_FULL;
          end else if (out_fire) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          // in_ready is low here, so only the output side can move.
          if (out_fire) begin
            load_a   = 1'b1;
            a_from_b = 1'b1;
            state_d  = SKID_ONE;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SKID_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      slot_a      <= '0;
      slot_b      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != SKID_FULL);
      out_valid_q <= (state_d != SKID_EMPTY);
      if (load_a) slot_a <= a_from_b ? slot_b : dec_entry;
      if (load_b) slot_b <= dec_entry;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_inst  = slot_a.inst;
  assign out_tag   = slot_a.tag;
  assign out_imm   = slot_a.imm;
  assign out_fmt   = slot_a.fmt;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Bench for imm_gen_pipe (XLEN=32, TAG_W=5). A queue holds the entries the
// block must still deliver; the immediate for each is computed from the
// instruction-format rules. Decode vectors, backpressure, flush and
// asynchronous reset are driven as directed sequences.
// Honours IMM_GEN_ZICSR_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int EW    = 32 + TAG_W + XLEN + 3;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_inst = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_inst;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: finished=0 want=1");
    $fatal(1);
  end

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_tag   (out_tag),
    .out_imm   (out_imm),
    .out_fmt   (out_fmt),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [EW-1:0]    exp_q[$];
  logic [TAG_W-1:0] seen_tags[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Format rules written directly from the instruction-set definitions.
  function automatic logic [XLEN+2:0] model_dec(input logic [31:0] inst);
    logic signed [63:0] v;
    logic [2:0]  f;
    logic [11:0] s12;
    logic [12:0] b13;
    logic [20:0] j21;
    v = 0;
    f = 3'd0;
    case (inst[6:0])
      7'h03, 7'h13, 7'h67: begin v = $signed(inst[31:20]); f = 3'd1; end
      7'h1B: if (XLEN == 64) begin v = $signed(inst[31:20]); f = 3'd1; end
      7'h23: begin s12 = {inst[31:25], inst[11:7]}; v = $signed(s12); f = 3'd2; end
      7'h63: begin
        b13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        v = $signed(b13); f = 3'd3;
      end
      7'h37, 7'h17: begin v = $signed({inst[31:12], 12'h000}); f = 3'd4; end
      7'h6F: begin
        j21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        v = $signed(j21); f = 3'd5;
      end
`ifdef IMM_GEN_ZICSR_EN
      7'h73: if (inst[14]) begin v = {59'b0, inst[19:15]}; f = 3'd6; end
`endif
      default: begin v = 0; f = 3'd0; end
    endcase
    return {f, v[XLEN-1:0]};
  endfunction

  // Model: an ordered list of at most two pending entries.
  logic             m_in_fire;
  logic             m_out_fire;
  logic [XLEN+2:0]  m_dec;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      m_out_fire = (exp_q.size() > 0) && out_ready;
      m_in_fire  = in_valid && (exp_q.size() < 2);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_out_fire) void'(exp_q.pop_front());
        if (m_in_fire) begin
          m_dec = model_dec(in_inst);
          exp_q.push_back({in_inst, in_tag, m_dec[XLEN-1:0], m_dec[XLEN+2:XLEN]});
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  logic [EW-1:0] cur;
  always @(negedge clk) begin
    if (reset_n) begin
      check("out_valid", out_valid, exp_q.size() > 0);
      check("in_ready", in_ready, exp_q.size() < 2);
      if (exp_q.size() > 0) begin
        cur = exp_q[0];
        check("out_inst", out_inst, cur[EW-1 -: 32]);
        check("out_tag", out_tag, cur[EW-33 -: TAG_W]);
        check("out_imm", out_imm, cur[3 +: XLEN]);
        check("out_fmt", out_fmt, cur[2:0]);
      end
      if (out_valid && out_ready) seen_tags.push_back(out_tag);
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the capturing edge.
  task automatic send(input logic [31:0] inst, input logic [TAG_W-1:0] tag);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_tag   = tag;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 40);
    check("send_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_expect(input string name, input logic [31:0] inst,
                             input logic [TAG_W-1:0] tag,
                             input logic [XLEN-1:0] imm, input logic [2:0] fmt);
    send(inst, tag);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_tag"}, out_tag, tag);
    check({name, "_imm"}, out_imm, imm);
    check({name, "_fmt"}, out_fmt, fmt);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    check("drain_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  function automatic int count_tag(input logic [TAG_W-1:0] t);
    int c;
    c = 0;
    foreach (seen_tags[i]) if (seen_tags[i] == t) c++;
    return c;
  endfunction

  // ---------------- stimulus ----------------
  logic [31:0] tbl[10];
  logic [29:0] rdy_pat;

  initial begin
    // Pin the model with hand-computed values.
    check("model_addi", model_dec(32'hFFF00093), {3'd1, 32'hFFFFFFFF});
    check("model_beq",  model_dec(32'hFE000EE3), {3'd3, 32'hFFFFFFFC});
    check("model_jal",  model_dec(32'h0010006F), {3'd5, 32'h00000800});
    check("model_sw",   model_dec(32'hFE20AC23), {3'd2, 32'hFFFFFFF8});

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_imm", out_imm, 0);
    check("rst_out_fmt", out_fmt, 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_out_tag", out_tag, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Decode vectors, one-cycle latency with an empty output slot.
    out_ready = 1'b1;
    send_expect("addi", 32'hFFF00093, 5'd10, 32'hFFFFFFFF, 3'd1);
    send_expect("lui",  32'h123450B7, 5'd11, 32'h12345000, 3'd4);
    send_expect("beq",  32'hFE000EE3, 5'd12, 32'hFFFFFFFC, 3'd3);
    send_expect("jal",  32'h0010006F, 5'd13, 32'h00000800, 3'd5);
    send_expect("sw",   32'hFE20AC23, 5'd14, 32'hFFFFFFF8, 3'd2);
`ifdef IMM_GEN_ZICSR_EN
    send_expect("csrrwi", 32'h3002D073, 5'd15, 32'd5, 3'd6);
`else
    send_expect("csrrwi", 32'h3002D073, 5'd15, 32'd0, 3'd0);
`endif
    send_expect("opc7f",  32'h0000007F, 5'd16, 32'd0, 3'd0);
    send_expect("addiw32", 32'hFFF0009B, 5'd17, 32'd0, 3'd0);
    drain();

    // Backpressure: two accepted, third held until the output drains.
    out_ready = 1'b0;
    seen_tags.delete();
    send(32'hFFF00093, 5'd1);
    send(32'h123450B7, 5'd2);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_head_tag", out_tag, 1);
    fork
      send(32'hFE000EE3, 5'd3);
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", seen_tags.size(), 3);
    if (seen_tags.size() == 3) begin
      check("bp_order0", seen_tags[0], 1);
      check("bp_order1", seen_tags[1], 2);
      check("bp_order2", seen_tags[2], 3);
    end

    // Flush while FULL, with a same-cycle input.
    out_ready = 1'b0;
    send(32'hFFF00093, 5'd5);
    send(32'h123450B7, 5'd6);
    in_valid = 1'b1; in_inst = 32'h0010006F; in_tag = 5'd7; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_full_out_valid", out_valid, 0);
    check("flush_full_in_ready", in_ready, 1);
    // Flush while ONE, where the same-cycle input would otherwise be taken.
    send(32'hFE20AC23, 5'd4);
    in_valid = 1'b1; in_inst = 32'hFE000EE3; in_tag = 5'd18; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_one_out_valid", out_valid, 0);
    seen_tags.delete();
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("flush_tag7_absent", count_tag(5'd7), 0);
    check("flush_tag18_absent", count_tag(5'd18), 0);
    check("flush_idle", out_valid, 0);

    // Asynchronous reset between edges while FULL.
    out_ready = 1'b0;
    send(32'hFFF00093, 5'd8);
    send(32'h123450B7, 5'd9);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_out_valid", out_valid, 0);
    check("areset_in_ready", in_ready, 1);
    check("areset_out_tag", out_tag, 0);
    check("areset_out_imm", out_imm, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_expect("post_reset", 32'h0010006F, 5'd19, 32'h00000800, 3'd5);
    drain();

    // Mixed vectors under an irregular out_ready pattern.
    tbl[0] = 32'hFFFFF097; tbl[1] = 32'h00008067; tbl[2] = 32'h00209463;
    tbl[3] = 32'hFF9FF0EF; tbl[4] = 32'h7FF00093; tbl[5] = 32'h80000037;
    tbl[6] = 32'h0020B423; tbl[7] = 32'h3002D073; tbl[8] = 32'h80000063;
    tbl[9] = 32'h00000033;
    rdy_pat = 30'b101100111000101101001110010110;
    fork
      for (int i = 0; i < 10; i++) send(tbl[i], 5'(20 + i));
      for (int k = 0; k < 30; k++) begin
        out_ready = rdy_pat[k];
        @(posedge clk);
        #1;
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes the immediate for every RV32I/RV64I format, sign-extended to XLEN.
- Each result is emitted with a format tag, behind a 2-entry skid buffer, so fetch/decode backpressure never forms a combinational ready path.
- Sits between the instruction fetch register and the decode/ALU-operand mux.

Parameters:
- XLEN, 32, datapath width of the immediate output; legal values 32 or 64.
- TAG_W, 5, width of the opaque sideband tag (e.g. ROB or PC index) carried alongside each instruction.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  block can accept; driven directly from a register.
- in_inst  in  32  instruction word.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_inst  out  32  instruction word, passed through.
- out_tag  out  TAG_W  tag, passed through.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  imm_fmt_e code: NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6.

Behaviour:
- Reset (asynchronous, reset_n low): out_valid=0, in_ready=1, out_imm=0, out_fmt=NONE, out_inst=0, out_tag=0, both buffer entries invalid.
- Transfers:
  - Input transfer when in_valid&in_ready.
  - Output transfer when out_valid&out_ready.
  - Latency: instruction accepted in cycle N appears on out_* in cycle N+1 when the output slot is empty.
- Decode is applied at input capture; stored entries hold the finished immediate.
- Opcode to format, with sign bit s=inst[31] replicated up to XLEN:
  - 0000011 load, 0010011 op-imm, 1100111 jalr, 0011011 op-imm-32 (XLEN=64 only): I = s-ext inst[31:20].
  - 0100011: S = s-ext {inst[31:25], inst[11:7]}.
  - 1100011: B = s-ext {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - 0110111 lui, 0010111 auipc: U = s-ext {inst[31:12], 12'b0}. Upper 32 bits are sign copies when XLEN=64.
  - 1101111: J = s-ext {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Any other opcode: imm=0, fmt=NONE. The entry is still passed; it is not an error.
- Skid buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0; entry B holds the word accepted while out_ready was low.
- Transitions:
  - EMPTY, input transfer -> ONE.
  - ONE, input and output transfer together -> ONE (new entry in output slot).
  - ONE, input only -> FULL.
  - ONE, output only -> EMPTY.
  - FULL, output transfer -> ONE (B moves to output slot).
- Order is preserved; no entry is ever dropped or duplicated.
- flush: next state EMPTY, in_ready=1. An in_valid in the same cycle is dropped (flush wins). out_valid may be high in the flush cycle itself; downstream must ignore it.
- reset_n assertion mid-operation clears all state immediately, independent of clk.

Optional Feature:
- Macro: IMM_GEN_ZICSR_EN.
- When defined: opcode 1110011 with funct3[2]=1 (csrrwi/csrrsi/csrrci) yields fmt=Z, imm = zero-extended inst[19:15].
- When undefined: opcode 1110011 yields fmt=NONE, imm=0.

Decomposition:
- Package imm_gen_pkg:
  - imm_fmt_e enum.
  - Opcode localparams (OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM).
  - Packed struct imm_entry_t {inst, tag, imm, fmt}.
- Sub-module imm_decode: pure combinational decoder (inst -> imm, fmt), parametrised by XLEN.
- imm_gen_pipe itself holds only the skid buffer and control.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), XLEN=32, out_ready=1 -> next cycle out_imm=0xFFFFFFFF, fmt=I; with XLEN=64 -> 0xFFFFFFFFFFFFFFFF.
- lui x1,0x12345 (0x123450B7) -> out_imm=0x12345000, fmt=U; beq x0,x0,-4 (0xFE000EE3) -> 0xFFFFFFFC, fmt=B; jal x0,+2048 (0x0010006F) -> 0x00000800, fmt=J.
- Backpressure: hold out_ready=0, drive tags 1,2,3 back-to-back -> in_ready falls after tag 2 is accepted, tag 3 held upstream; release out_ready -> out_tag sequence 1,2,3, none lost.
- Flush: buffer FULL, assert flush with in_valid=1 (tag 7) -> next cycle out_valid=0, in_ready=1; tag 7 never appears at output.
- Async reset: assert reset_n=0 between clock edges while FULL -> out_valid=0 and in_ready=1 immediately, before the next edge.
- csrrwi x0,mstatus,5 (0x3002D073) -> with IMM_GEN_ZICSR_EN: imm=5, fmt=Z; without: imm=0, fmt=NONE; opcode 0x7F -> imm=0, fmt=NONE.
